// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - default operand/opcode widths
//   - supported opcode encodings (add, sub, and, or)
//   - op_legal(): 1 when an opcode is one of the four supported encodings
// No ports. Imported by alu_core and alu_arbiter.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int OPW_DEF   = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;

    function automatic logic op_legal(input logic [3:0] opcode);
        return opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the request and response handshakes of the shared ALU.
//   req_valid[1:0]   : per-requester request valid (bit i = requester i)
//   req_ready[1:0]   : per-requester accept (transfer when valid & ready)
//   reqN_opcode/in1/in2 : opcode and operands of requester N
//   rsp_valid        : response register holds a result
//   rsp_ready        : consumer accepts the response
//   rsp_id           : requester that issued the held result
//   rsp_result       : held result
//   rsp_err          : held op had an unsupported opcode
// Modports: master = requesters + response consumer, slave = the arbiter.
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OPW-1:0]   req0_opcode;
    logic [WIDTH-1:0] req0_in1;
    logic [WIDTH-1:0] req0_in2;
    logic [OPW-1:0]   req1_opcode;
    logic [WIDTH-1:0] req1_in1;
    logic [WIDTH-1:0] req1_in2;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;

    modport master (
        output req_valid, req0_opcode, req0_in1, req0_in2,
               req1_opcode, req1_in1, req1_in2, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req0_opcode, req0_in1, req0_in2,
               req1_opcode, req1_in1, req1_in2, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU.
//   opcode : operation select (add, sub, and, or; anything else gives 0)
//   in1    : operand A
//   in2    : operand B
//   result : A op B; add/sub wrap modulo 2^WIDTH, no carry/borrow out
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        result = '0;
        case (opcode)
            OPW'(OP_ADD): result = in1 + in2;
            OPW'(OP_SUB): result = in1 - in2;
            OPW'(OP_AND): result = in1 & in2;
            OPW'(OP_OR):  result = in1 | in2;
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters with round-robin arbitration and
// a single-entry response register.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous, active-high reset
//   bus : alu_arbiter_if.slave (request handshakes in, response out)
// The slot accepts a new op whenever it is empty or being drained in the
// same cycle, giving one op per cycle while rsp_ready stays high.
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_err_q;
    logic             last_grant_q;

    logic             can_accept;
    logic             grant;
    logic [1:0]       ready;
    logic             accept;
    logic [OPW-1:0]   sel_opcode;
    logic [WIDTH-1:0] sel_in1;
    logic [WIDTH-1:0] sel_in2;
    logic [WIDTH-1:0] alu_result;

    assign can_accept = !rsp_valid_q || bus.rsp_ready;

    // A lone requester always wins; under contention the one that did not
    // win last time goes next. With nobody asking the choice is irrelevant.
    always_comb begin
        grant = ~last_grant_q;
        if (bus.req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    assign ready  = (can_accept && !rst) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept = |(bus.req_valid & ready);

    assign sel_opcode = grant ? bus.req1_opcode : bus.req0_opcode;
    assign sel_in1    = grant ? bus.req1_in1    : bus.req0_in1;
    assign sel_in2    = grant ? bus.req1_in2    : bus.req0_in2;

    alu_core #(
        .WIDTH(WIDTH),
        .OPW  (OPW)
    ) u_alu_core (
        .opcode(sel_opcode),
        .in1   (sel_in1),
        .in2   (sel_in2),
        .result(alu_result)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the whole response slot is cleared on reset, not just the
            // valid bit, so the visible outputs are deterministic afterwards.
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant;
            rsp_result_q <= alu_result;
            rsp_err_q    <= !op_legal(4'(sel_opcode));
            last_grant_q <= grant;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            // Drained with nothing to refill: payload stays, only valid drops.
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the response slot and who won last.
    logic        m_valid;
    logic        m_id;
    logic [15:0] m_result;
    logic        m_err;
    logic        m_last;
    logic [1:0]  m_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int r;
        case (op)
            4'd0:    r = (int'(a) + int'(b)) % 65536;
            4'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
            4'd8:    r = int'(a & b);
            4'd9:    r = int'(a | b);
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    // One clock: compare outputs at the falling edge, advance the model at
    // the rising edge, return 1 time unit later with inputs free to change.
    task automatic cycle();
        logic       g;
        logic [1:0] exp_ready;
        logic [3:0] op;
        logic [15:0] a, b;
        @(negedge clk);
        check("rsp_valid",  32'(bus.rsp_valid),  32'(m_valid));
        check("rsp_id",     32'(bus.rsp_id),     32'(m_id));
        check("rsp_result", 32'(bus.rsp_result), 32'(m_result));
        check("rsp_err",    32'(bus.rsp_err),    32'(m_err));
        if (bus.req_valid == 2'b11) g = !m_last;
        else                        g = bus.req_valid[1];
        exp_ready = (!rst && (!m_valid || bus.rsp_ready)) ? (g ? 2'b10 : 2'b01) : 2'b00;
        if (rst || bus.req_valid != 2'b00 || exp_ready == 2'b00)
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        m_acc = bus.req_valid & exp_ready;
        op = g ? bus.req1_opcode : bus.req0_opcode;
        a  = g ? bus.req1_in1    : bus.req0_in1;
        b  = g ? bus.req1_in2    : bus.req0_in2;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_err = 1'b0; m_last = 1'b1;
            m_acc = 2'b00;
        end else if (m_acc != 2'b00) begin
            m_valid  = 1'b1;
            m_id     = g;
            m_result = ref_alu(op, a, b);
            m_err    = !(op == 4'd0 || op == 4'd1 || op == 4'd8 || op == 4'd9);
            m_last   = g;
        end else if (m_valid && bus.rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b);
        if (i == 0) begin
            bus.req0_opcode = op; bus.req0_in1 = a; bus.req0_in2 = b;
        end else begin
            bus.req1_opcode = op; bus.req1_in1 = a; bus.req1_in2 = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        cycle();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd8;
            3: return 4'd9;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic [15:0] held;
        logic [1:0]  pend;

        m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_err = 1'b0; m_last = 1'b1;
        m_acc = 2'b00;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        set_req(0, 4'd0, 16'h0, 16'h0);
        set_req(1, 4'd0, 16'h0, 16'h0);
        #1;
        do_reset();
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Single request after reset: 3 + 4 from requester 0.
        bus.req_valid = 2'b01;
        set_req(0, 4'd0, 16'h0003, 16'h0004);
        cycle();
        bus.req_valid = 2'b00;
        check("single_result", 32'(bus.rsp_result), 32'h0007);
        check("single_id",     32'(bus.rsp_id),     32'd0);
        check("single_valid",  32'(bus.rsp_valid),  32'd1);

        // Wrap-around on both subtract and add.
        bus.req_valid = 2'b10;
        set_req(1, 4'd1, 16'h0000, 16'h0001);
        cycle();
        check("sub_wrap", 32'(bus.rsp_result), 32'h0000_FFFF);
        check("sub_id",   32'(bus.rsp_id),     32'd1);
        set_req(1, 4'd0, 16'hFFFF, 16'h0002);
        cycle();
        bus.req_valid = 2'b00;
        check("add_wrap", 32'(bus.rsp_result), 32'h0001);

        // Contention straight after reset: 0,1,0,1 back to back.
        do_reset();
        bus.req_valid = 2'b11;
        set_req(0, 4'd0, 16'h0010, 16'h0001);
        set_req(1, 4'd9, 16'h0100, 16'h0002);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("contend_id",    32'(bus.rsp_id),    32'(k % 2));
            check("contend_valid", 32'(bus.rsp_valid), 32'd1);
        end

        // Backpressure: three stalled cycles, then release.
        bus.req_valid = 2'b01;
        set_req(0, 4'd8, 16'hF0F0, 16'h0FF0);
        bus.rsp_ready = 1'b0;
        held = bus.rsp_result;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_hold", 32'(bus.rsp_result), 32'(held));
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check("release_result", 32'(bus.rsp_result), 32'h00F0);
        check("release_id",     32'(bus.rsp_id),     32'd0);

        // Illegal opcode then a legal AND.
        set_req(0, 4'd5, 16'h1234, 16'h0001);
        cycle();
        check("illegal_result", 32'(bus.rsp_result), 32'd0);
        check("illegal_err",    32'(bus.rsp_err),    32'd1);
        set_req(0, 4'd8, 16'hF0F0, 16'h0FF0);
        cycle();
        check("and_result", 32'(bus.rsp_result), 32'h00F0);
        check("and_err",    32'(bus.rsp_err),    32'd0);

        // Reset while a response is stalled.
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        cycle();
        do_reset();
        check("rst_stall_valid",  32'(bus.rsp_valid),  32'd0);
        check("rst_stall_result", 32'(bus.rsp_result), 32'd0);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        cycle();
        check("rst_first_grant", 32'(bus.rsp_id), 32'd0);
        bus.req_valid = 2'b00;
        cycle();

        // Randomized traffic; requesters hold payload until accepted.
        pend = 2'b00;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, rand_op(), 16'($urandom), 16'($urandom));
                end
            end
            bus.req_valid = pend;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
            rst = 1'b0;
            pend = pend & ~m_acc;
        end
        bus.req_valid = 2'b00;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
